aes_subbytes_seq: RTL
=====================

# aes_subbytes_seq

Sequencer that drives the two-stage pipelined, masked AES S-box datapath for a full 128-bit state. It accepts one state plus a mode bit and splits each byte into two Boolean shares with a fresh mask. It then issues one byte per cycle into the S-box, recombines the returned output shares, and presents the SubBytes (or InvSubBytes) result on a valid/ready handshake. It sits between the round controller and the S-box instance.

## Interface
Parameters:
- NBYTES, 16, bytes per state; fixed at 16 for AES-128.
- SBOX_LAT, 2, cycles from S-box input to S-box output; matches the S-box register depth.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  state_in/ed_in valid.
- in_ready  out  1  sequencer idle, can accept.
- state_in  in  128  byte i = state_in[8i+7:8i].
- ed_in  in  1  1 = encrypt (forward S-box), 0 = decrypt (inverse S-box).
- rnd_in  in  36  fresh randomness each cycle; [7:0] is the byte mask, [35:8] is S-box internal randomness.
- out_valid  out  1  state_out holds a complete result.
- out_ready  in  1  consumer accepts result.
- state_out  out  128  substituted state, same byte ordering as state_in.
- sbox_a  out  8  share 0 to S-box.
- sbox_b  out  8  share 1 to S-box.
- sbox_ed  out  1  mode to S-box.
- sbox_random  out  28  equals rnd_in[35:8], combinational pass-through.
- sbox_s0  in  8  output share 0 from S-box.
- sbox_s1  in  8  output share 1 from S-box.

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid, register state_in into a state buffer, ed_in into ed_q, clear issue counter; go to ISSUE.
  - ISSUE: 16 cycles, issue counter i=0..15. sbox_a = byte_i ^ rnd_in[7:0]; sbox_b = rnd_in[7:0]. At i=15 go to DRAIN.
  - DRAIN: SBOX_LAT cycles, no issue. Then go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- sbox_a/sbox_b are 0 whenever not in ISSUE. The unmasked byte never appears on sbox_a when the mask is nonzero.
- sbox_ed = ed_q, held constant from acceptance through DRAIN. The S-box output affine stage depends on mode combinationally, so mode must not change while results are in flight. ed_in is ignored outside IDLE.
- Capture: a SBOX_LAT-deep valid/index shift pipe tracks issued bytes. When the pipe tail is valid with index j, state_out[8j+7:8j] <= sbox_s0 ^ sbox_s1.
- Recombined byte equals S(x) when encrypting and S^-1(x) when decrypting, independent of mask values.
- state_out updates only via capture and holds stable in DONE. It is not cleared on new acceptance; bytes are overwritten as captured.
- in_ready and out_valid are never high in the same cycle. There is no accept in DONE, even if in_valid and out_ready coincide; the next accept is earliest in the cycle after the DONE→IDLE transition.

## Timing
- Reset values: in_ready=1, out_valid=0, state_out=0, sbox_a=0, sbox_b=0, sbox_ed=1, FSM=IDLE, counters and pipe cleared.
- Acceptance edge = E0. Byte i is driven during cycle i after E0 (i=0..15) and captured at the end of cycle i+2.
- The last capture completes at the end of cycle 17. out_valid is high from cycle 18: acceptance-to-out_valid latency is 18 cycles.
- Minimum throughput: one state per 20 cycles (accept, 18 cycles, out_ready in DONE, then IDLE).
- Holding out_ready low keeps the block in DONE indefinitely, with state_out and out_valid stable.
- rst_n low mid-ISSUE or mid-DRAIN: immediate return to reset values. In-flight S-box results are discarded, because the pipe is cleared before they are captured.

## Test plan
- Encrypt, state_in=0, random rnd_in → after 18 cycles state_out=0x6363…63, out_valid=1.
- Decrypt, state_in=0x6363…63 → state_out=0. Byte checks: 0x53→0xED (encrypt); 0xED→0x53 (decrypt); 0x01→0x7C (encrypt).
- Same state encrypted with rnd_in held at 0 and with rnd_in randomized every cycle → identical state_out. With mask ≠0, sbox_a ≠ raw byte in every ISSUE cycle.
- ed_in toggled every cycle during ISSUE/DRAIN → sbox_ed constant, result matches the latched mode.
- out_ready held low 50 cycles in DONE → out_valid stays 1, state_out stable, in_ready 0. Release → IDLE next cycle, then back-to-back accept.
- rst_n pulsed low at cycle 10 of ISSUE → all outputs at reset values. A following fresh state completes correctly with no stale bytes captured.

Source files
------------

// File: rtl/aes_subbytes_seq_if.sv
// Round-controller side of the masked SubBytes sequencer: state in, result out,
// both on valid/ready, plus mode and per-cycle randomness.
interface aes_subbytes_seq_if #(
    parameter int NBYTES = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [8*NBYTES-1:0]   state_in;
    logic                  ed_in;
    logic [35:0]           rnd_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [8*NBYTES-1:0]   state_out;

    modport master (
        output in_valid, state_in, ed_in, rnd_in, out_ready,
        input  in_ready, out_valid, state_out
    );

    modport slave (
        input  in_valid, state_in, ed_in, rnd_in, out_ready,
        output in_ready, out_valid, state_out
    );
endinterface

// File: rtl/aes_subbytes_seq.sv
// Feeds one masked byte per cycle into a pipelined two-share AES S-box and
// recombines the returned shares into the SubBytes / InvSubBytes state.
module aes_subbytes_seq #(
    parameter int NBYTES   = 16,
    parameter int SBOX_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    aes_subbytes_seq_if.slave bus,
    output logic [7:0]        sbox_a,
    output logic [7:0]        sbox_b,
    output logic              sbox_ed,
    output logic [27:0]       sbox_random,
    input  logic [7:0]        sbox_s0,
    input  logic [7:0]        sbox_s1
);
    // state | meaning
    // IDLE  | ready for a new state; latches state and mode on in_valid
    // ISSUE | drives byte idx_q, masked, into the S-box (NBYTES cycles)
    // DRAIN | waits SBOX_LAT cycles for in-flight bytes to come back
    // DONE  | result valid; holds until out_ready
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int SW = 8 * NBYTES;
    localparam int IW = $clog2(NBYTES);
    localparam int DW = (SBOX_LAT > 1) ? $clog2(SBOX_LAT) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    state_t                        state_q, state_d;
    logic [SW-1:0]                 buf_q;
    logic                          ed_q;
    logic [IW-1:0]                 idx_q;
    logic [DW-1:0]                 drain_q;
    logic [SBOX_LAT-1:0]           pipe_v;
    logic [SBOX_LAT-1:0][IW-1:0]   pipe_idx;
    logic [SW-1:0]                 out_q;

    logic       accept;
    logic       issue;
    logic       drain_ld;
    logic       in_ready_c;
    logic       out_valid_c;
    logic [7:0] cur_byte;
    logic [7:0] mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        issue       = 1'b0;
        drain_ld    = 1'b0;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                issue = 1'b1;
                if (idx_q == LAST_IDX) begin
                    drain_ld = 1'b1;
                    state_d  = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Mode is latched only at acceptance: the S-box output affine stage reads
    // sbox_ed combinationally, so it must stay put while bytes are in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q    <= '0;
            ed_q     <= 1'b1;
            idx_q    <= '0;
            drain_q  <= '0;
            pipe_v   <= '0;
            pipe_idx <= '0;
            out_q    <= '0;
        end else begin
            if (accept) begin
                buf_q <= bus.state_in;
                ed_q  <= bus.ed_in;
                idx_q <= '0;
            end else if (issue) begin
                idx_q <= idx_q + IW'(1);
            end

            if (drain_ld) begin
                drain_q <= DW'(SBOX_LAT - 1);
            end else if (state_q == DRAIN && drain_q != '0) begin
                drain_q <= drain_q - DW'(1);
            end

            pipe_v[0]   <= issue;
            pipe_idx[0] <= idx_q;
            for (int k = 1; k < SBOX_LAT; k++) begin
                pipe_v[k]   <= pipe_v[k-1];
                pipe_idx[k] <= pipe_idx[k-1];
            end

            if (pipe_v[SBOX_LAT-1]) begin
                out_q[{pipe_idx[SBOX_LAT-1], 3'b000} +: 8] <= sbox_s0 ^ sbox_s1;
            end
        end
    end

    assign cur_byte = buf_q[{idx_q, 3'b000} +: 8];
    assign mask     = bus.rnd_in[7:0];

    // Share 1 is the bare mask, so the raw byte only leaves the block masked.
    assign sbox_a      = issue ? (cur_byte ^ mask) : 8'h00;
    assign sbox_b      = issue ? mask : 8'h00;
    assign sbox_ed     = ed_q;
    assign sbox_random = bus.rnd_in[35:8];

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.state_out = out_q;
endmodule
